alu_arbiter: RTL and testbench

Two-requester round-robin front end for the shared N-bit ALU, which supports add, subtract, AND and OR with NZCV flags. The block arbitrates between two independent valid/ready request channels and issues one operation at a time to a single internal ALU instance. It registers the result and flags, and returns them on the winning requester's valid/ready response channel. It sits between the two datapath clients and the ALU, so neither client needs its own ALU.

---
 rtl/alu_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-channel round-robin front end for a shared add/sub/and/or ALU.
// One transaction in flight at a time: IDLE accepts, EXEC computes, RESP holds the answer.
module alu_arbiter #(
  parameter int Nbits = 8
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [Nbits-1:0] req0_a,
  input  logic [Nbits-1:0] req0_b,
  input  logic [1:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [Nbits-1:0] req1_a,
  input  logic [Nbits-1:0] req1_b,
  input  logic [1:0]       req1_op,

  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [Nbits-1:0] resp0_result,
  output logic [3:0]       resp0_nzcv,

  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [Nbits-1:0] resp1_result,
  output logic [3:0]       resp1_nzcv
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Returns {result, N, Z, C, V}; subtraction is a + ~b + 1 so C means "no borrow".
  function automatic logic [Nbits+3:0] alu_eval(
    input logic signed [Nbits-1:0] a,
    input logic signed [Nbits-1:0] b,
    input logic [1:0]              op
  );
    logic [Nbits-1:0] b_eff;
    logic [Nbits:0]   sum;
    logic [Nbits-1:0] res;
    logic             c;
    logic             v;
    b_eff = (op == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{Nbits{1'b0}}, (op == OP_SUB)};
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        res = sum[Nbits-1:0];
        c   = sum[Nbits];
        v   = (a[Nbits-1] == b_eff[Nbits-1]) && (res[Nbits-1] != a[Nbits-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      default: res = '0;
    endcase
    return {res, res[Nbits-1], (res == '0), c, v};
  endfunction

  logic [1:0]              state_q, state_d;
  logic                    prio_q, prio_d;
  logic                    gnt_q, gnt_d;
  logic signed [Nbits-1:0] a_q, a_d;
  logic signed [Nbits-1:0] b_q, b_d;
  logic [1:0]              op_q, op_d;

  logic                    resp0_valid_q, resp0_valid_d;
  logic [Nbits-1:0]        resp0_result_q, resp0_result_d;
  logic [3:0]              resp0_nzcv_q, resp0_nzcv_d;
  logic                    resp1_valid_q, resp1_valid_d;
  logic [Nbits-1:0]        resp1_result_q, resp1_result_d;
  logic [3:0]              resp1_nzcv_q, resp1_nzcv_d;

  logic                    grant;
  logic                    in_idle;
  logic                    resp_hs;
  logic [Nbits+3:0]        alu_out;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = prio_q;
    else if (req1_valid)          grant = 1'b1;
  end

  assign in_idle    = reset_n && (state_q == ST_IDLE);
  assign req0_ready = in_idle && req0_valid && !grant;
  assign req1_ready = in_idle && req1_valid && grant;

  assign alu_out = alu_eval(a_q, b_q, op_q);
  assign resp_hs = gnt_q ? (resp1_valid_q && resp1_ready) : (resp0_valid_q && resp0_ready);

  always_comb begin
    state_d        = state_q;
    prio_d         = prio_q;
    gnt_d          = gnt_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    resp0_valid_d  = resp0_valid_q;
    resp0_result_d = resp0_result_q;
    resp0_nzcv_d   = resp0_nzcv_q;
    resp1_valid_d  = resp1_valid_q;
    resp1_result_d = resp1_result_q;
    resp1_nzcv_d   = resp1_nzcv_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          gnt_d   = grant;
          a_d     = grant ? req1_a  : req0_a;
          b_d     = grant ? req1_b  : req0_b;
          op_d    = grant ? req1_op : req0_op;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (gnt_q) begin
          resp1_valid_d  = 1'b1;
          resp1_result_d = alu_out[Nbits+3:4];
          resp1_nzcv_d   = alu_out[3:0];
        end else begin
          resp0_valid_d  = 1'b1;
          resp0_result_d = alu_out[Nbits+3:4];
          resp0_nzcv_d   = alu_out[3:0];
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_hs) begin
          if (gnt_q) resp1_valid_d = 1'b0;
          else       resp0_valid_d = 1'b0;
          prio_d  = ~gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      prio_q         <= 1'b0;
      gnt_q          <= 1'b0;
      resp0_valid_q  <= 1'b0;
      resp0_result_q <= '0;
      resp0_nzcv_q   <= '0;
      resp1_valid_q  <= 1'b0;
      resp1_result_q <= '0;
      resp1_nzcv_q   <= '0;
    end else begin
      state_q        <= state_d;
      prio_q         <= prio_d;
      gnt_q          <= gnt_d;
      resp0_valid_q  <= resp0_valid_d;
      resp0_result_q <= resp0_result_d;
      resp0_nzcv_q   <= resp0_nzcv_d;
      resp1_valid_q  <= resp1_valid_d;
      resp1_result_q <= resp1_result_d;
      resp1_nzcv_q   <= resp1_nzcv_d;
    end
  end

  // Operand registers are only consumed in EXEC, so they need no reset.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  assign resp0_valid  = resp0_valid_q;
  assign resp0_result = resp0_result_q;
  assign resp0_nzcv   = resp0_nzcv_q;
  assign resp1_valid  = resp1_valid_q;
  assign resp1_result = resp1_result_q;
  assign resp1_nzcv   = resp1_nzcv_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: inputs change away from the rising edge,
// outputs are sampled 1 time unit after it or after the falling edge.
module tb_alu_arbiter;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic       resp0_valid, resp1_valid;
  logic       resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [7:0] resp0_result, resp1_result;
  logic [3:0] resp0_nzcv, resp1_nzcv;

  int n_cmp = 0;
  int n_fail = 0;

  alu_arbiter #(.Nbits(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result), .resp0_nzcv(resp0_nzcv),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result), .resp1_nzcv(resp1_nzcv)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Issues one request on a lone channel with both response readies high.
  // lat = rising edges after the accept edge until respX_valid is seen (-1: timeout).
  task automatic run_op(input int ch, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic [3:0] nzcv, output int lat);
    logic acc;
    res = '0; nzcv = '0; lat = -1; acc = 1'b0;
    @(negedge clk);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    if (ch == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    for (int i = 0; i < 10 && !acc; i++) begin
      #1;
      acc = (ch == 0) ? req0_ready : req1_ready;
      if (!acc) @(negedge clk);
    end
    if (acc) begin
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i <= 10 && lat < 0; i++) begin
        if ((ch == 0) ? resp0_valid : resp1_valid) begin
          lat  = i;
          res  = (ch == 0) ? resp0_result : resp1_result;
          nzcv = (ch == 0) ? resp0_nzcv : resp1_nzcv;
        end else begin
          @(posedge clk); #1;
        end
      end
      if (lat >= 0) begin @(posedge clk); #1; end
    end else begin
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valid got %b want 00", {resp0_valid, resp1_valid}); end
    n_cmp++; if ({resp0_result, resp0_nzcv, resp1_result, resp1_nzcv} !== 24'h0) begin n_fail++;
      $display("FAIL reset_data got %h want 000000", {resp0_result, resp0_nzcv, resp1_result, resp1_nzcv}); end
    @(negedge clk);
    req0_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_single_add;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h7F; req0_b = 8'h01;
    resp0_ready = 1'b1; resp1_ready = 1'b0;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL add_ready got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n_cmp++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL add_exec_valid got %b want 0", resp0_valid); end
    @(posedge clk); #1;
    n_cmp++; if (resp0_valid !== 1'b1) begin n_fail++; $display("FAIL add_resp_valid got %b want 1", resp0_valid); end
    n_cmp++; if (resp0_result !== 8'h80) begin n_fail++; $display("FAIL add_result got %h want 80", resp0_result); end
    n_cmp++; if (resp0_nzcv !== 4'b1001) begin n_fail++; $display("FAIL add_nzcv got %b want 1001", resp0_nzcv); end
    n_cmp++; if ({resp1_valid, resp1_result, resp1_nzcv} !== 13'h0) begin n_fail++;
      $display("FAIL add_ch1_untouched got %h want 0000", {resp1_valid, resp1_result, resp1_nzcv}); end
    @(posedge clk); #1;
    n_cmp++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL add_handshake got %b want 0", resp0_valid); end
  endtask

  task automatic test_alu_edges;
    logic [7:0] res;
    logic [3:0] nzcv;
    int lat;
    run_op(1, OP_SUB, 8'h05, 8'h05, res, nzcv, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL sub_eq_latency got %0d want 1", lat); end
    n_cmp++; if ({res, nzcv} !== {8'h00, 4'b0110}) begin n_fail++; $display("FAIL sub_eq got %h/%b want 00/0110", res, nzcv); end
    run_op(1, OP_SUB, 8'h00, 8'h01, res, nzcv, lat);
    n_cmp++; if ({res, nzcv} !== {8'hFF, 4'b1000}) begin n_fail++; $display("FAIL sub_borrow got %h/%b want ff/1000", res, nzcv); end
    run_op(0, OP_ADD, 8'hFF, 8'h01, res, nzcv, lat);
    n_cmp++; if ({res, nzcv} !== {8'h00, 4'b0110}) begin n_fail++; $display("FAIL add_wrap got %h/%b want 00/0110", res, nzcv); end
    run_op(0, OP_SUB, 8'h80, 8'h01, res, nzcv, lat);
    n_cmp++; if ({res, nzcv} !== {8'h7F, 4'b0011}) begin n_fail++; $display("FAIL sub_ovf got %h/%b want 7f/0011", res, nzcv); end
    run_op(1, OP_OR, 8'h0F, 8'hA0, res, nzcv, lat);
    n_cmp++; if ({res, nzcv} !== {8'hAF, 4'b1000}) begin n_fail++; $display("FAIL or_neg got %h/%b want af/1000", res, nzcv); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    @(negedge clk);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_valid = 1'b1; req1_op = OP_OR;  req1_a = 8'h00; req1_b = 8'h00;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL sim_first_grant got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL sim_exec_ready got %b want 0", req1_ready); end
    @(posedge clk); #1;
    n_cmp++; if ({resp0_valid, resp0_result, resp0_nzcv} !== {1'b1, 8'h30, 4'b0000}) begin n_fail++;
      $display("FAIL sim_and got %b/%h/%b want 1/30/0000", resp0_valid, resp0_result, resp0_nzcv); end
    @(posedge clk); #1;
    n_cmp++; if ({resp0_valid, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL sim_second_grant got %b want 01", {resp0_valid, req1_ready}); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({resp1_valid, resp1_result, resp1_nzcv} !== {1'b1, 8'h00, 4'b0100}) begin n_fail++;
      $display("FAIL sim_or got %b/%h/%b want 1/00/0100", resp1_valid, resp1_result, resp1_nzcv); end
    @(posedge clk); #1;
  endtask

  task automatic test_alternate;
    bit seq[$];
    int both = 0;
    @(negedge clk);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h01; req0_b = 8'h01;
    req1_valid = 1'b1; req1_op = OP_OR;  req1_a = 8'h02; req1_b = 8'h04;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready && req1_ready) both++;
      else if (req0_ready) seq.push_back(1'b0);
      else if (req1_ready) seq.push_back(1'b1);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++; if (both !== 0) begin n_fail++; $display("FAIL alt_double_ready got %0d want 0", both); end
    n_cmp++; if (seq.size() !== 4) begin n_fail++; $display("FAIL alt_grant_count got %0d want 4", seq.size()); end
    for (int k = 0; k < seq.size(); k++) begin
      n_cmp++; if (seq[k] !== k[0]) begin n_fail++; $display("FAIL alt_grant_%0d got %0d want %0d", k, seq[k], k[0]); end
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    int idx[$];
    int r0 = 0;
    @(negedge clk);
    resp1_ready = 1'b1;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 8'h09; req1_b = 8'h03;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (req1_ready) idx.push_back(i);
      if (req0_ready) r0++;
      @(negedge clk);
    end
    req1_valid = 1'b0;
    n_cmp++; if (r0 !== 0) begin n_fail++; $display("FAIL b2b_req0_ready got %0d want 0", r0); end
    n_cmp++; if (idx.size() !== 3) begin n_fail++; $display("FAIL b2b_accepts got %0d want 3", idx.size()); end
    else begin
      n_cmp++; if ({idx[0], idx[1], idx[2]} !== {32'd0, 32'd3, 32'd6}) begin n_fail++;
        $display("FAIL b2b_spacing got %0d,%0d,%0d want 0,3,6", idx[0], idx[1], idx[2]); end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h12; req0_b = 8'h34;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 8'h10; req1_b = 8'h20;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_grant got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({resp0_valid, resp0_result, resp0_nzcv} !== {1'b1, 8'h46, 4'b0000}) begin n_fail++;
      $display("FAIL bp_resp got %b/%h/%b want 1/46/0000", resp0_valid, resp0_result, resp0_nzcv); end
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({resp0_valid, resp0_result, resp0_nzcv, req0_ready, req1_ready} !== {1'b1, 8'h46, 4'b0000, 2'b00}) begin n_fail++;
        $display("FAIL bp_hold_%0d got %b/%h/%b/%b want 1/46/0000/00", i, resp0_valid, resp0_result, resp0_nzcv, {req0_ready, req1_ready}); end
    end
    @(negedge clk);
    resp0_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({resp0_valid, req0_ready, req1_ready} !== 3'b001) begin n_fail++;
      $display("FAIL bp_release got %b want 001", {resp0_valid, req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp1_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({resp1_valid, resp1_result, resp1_nzcv} !== {1'b1, 8'hF0, 4'b1000}) begin n_fail++;
      $display("FAIL bp_req1 got %b/%h/%b want 1/f0/1000", resp1_valid, resp1_result, resp1_nzcv); end
    n_cmp++; if (resp0_result !== 8'h46) begin n_fail++; $display("FAIL bp_ch0_kept got %h want 46", resp0_result); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h55; req0_b = 8'h11;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({resp0_valid, resp1_valid, req0_ready, req1_ready} !== 4'b0000) begin n_fail++;
      $display("FAIL rst_mid_ctrl got %b want 0000", {resp0_valid, resp1_valid, req0_ready, req1_ready}); end
    n_cmp++; if ({resp0_result, resp0_nzcv, resp1_result, resp1_nzcv} !== 24'h0) begin n_fail++;
      $display("FAIL rst_mid_data got %h want 000000", {resp0_result, resp0_nzcv, resp1_result, resp1_nzcv}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b00) begin n_fail++;
        $display("FAIL rst_no_resp_%0d got %b want 00", i, {resp0_valid, resp1_valid}); end
    end
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_op = OP_AND; req1_a = 8'hFF; req1_b = 8'h0F;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL rst_prio got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({resp0_valid, resp0_result, resp0_nzcv} !== {1'b1, 8'h03, 4'b0000}) begin n_fail++;
      $display("FAIL rst_after_add got %b/%h/%b want 1/03/0000", resp0_valid, resp0_result, resp0_nzcv); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_alu_edges();
    test_simultaneous();
    test_alternate();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
